// File: rtl/crc_pkg.sv
// Shared types and defaults for the serial CRC engine.
package crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_GEN   = 2'd2,
      ST_CHK   = 2'd3
   } crc_state_e;

   localparam int         DEF_CRC_WIDTH = 8;
   localparam logic [7:0] DEF_POLY      = 8'h44;
   localparam logic [7:0] DEF_SEED      = 8'hD8;

   // Width of a counter that must reach crc_width without wrapping.
   function automatic int count_width(input int crc_width);
      return $clog2(crc_width + 1);
   endfunction

endpackage

// File: rtl/crc_serial_engine_if.sv
// Serial framer <-> CRC engine signal bundle.
interface crc_serial_engine_if;
   logic data;
   logic active;
   logic mode;
   logic ready;
   logic crc;
   logic valid;
   logic chk_done;
   logic crc_err;

   modport master (
      output data, active, mode,
      input  ready, crc, valid, chk_done, crc_err
   );

   modport slave (
      input  data, active, mode,
      output ready, crc, valid, chk_done, crc_err
   );
endinterface

// File: rtl/crc_lfsr_step.sv
// Combinational next-state of the Galois right-shift CRC register.
module crc_lfsr_step
   import crc_pkg::*;
#(
   parameter int                   CRC_WIDTH = DEF_CRC_WIDTH,
   parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(DEF_POLY)
) (
   input  logic [CRC_WIDTH-1:0] lfsr,
   input  logic                 data_in,
   input  logic                 shift_only,
   output logic [CRC_WIDTH-1:0] lfsr_next
);

   logic fb;
   assign fb = data_in ^ lfsr[0];

   always_comb begin
      lfsr_next = lfsr >> 1;
      if (!shift_only) begin
         lfsr_next[CRC_WIDTH-1] = fb;
         for (int i = 0; i < CRC_WIDTH - 1; i++) begin
            lfsr_next[i] = lfsr[i+1] ^ (POLY[i] & fb);
         end
      end
   end

endmodule

// File: rtl/crc_serial_engine.sv
// Serial CRC generator / checker: absorbs a frame LSB-first, then emits or compares the CRC.
//
// state    | meaning
// ST_IDLE  | ready for a frame; first active bit absorbed on entry edge
// ST_ACCUM | absorbing frame bits while active is high
// ST_GEN   | shifting the CRC out on crc with valid high
// ST_CHK   | comparing received CRC bits on data against the register
module crc_serial_engine
   import crc_pkg::*;
#(
   parameter int                   CRC_WIDTH = DEF_CRC_WIDTH,
   parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(DEF_POLY),
   parameter logic [CRC_WIDTH-1:0] SEED      = CRC_WIDTH'(DEF_SEED)
) (
   input logic              clk,
   input logic              rst_n,
   crc_serial_engine_if.slave bus
);

   localparam int             CW           = count_width(CRC_WIDTH);
   localparam logic [CW-1:0]  CNT_ONE      = CW'(1);
   localparam logic [CW-1:0]  CNT_GEN_LAST = CW'(CRC_WIDTH);
   localparam logic [CW-1:0]  CNT_CHK_LAST = CW'(CRC_WIDTH - 1);

   crc_state_e           state;
   logic [CRC_WIDTH-1:0] lfsr;
   logic [CRC_WIDTH-1:0] lfsr_next;
   logic [CW-1:0]        count;
   logic                 mode_q;
   logic                 err_acc;
   logic                 bit_err;
   logic                 shift_only;
   logic                 ready_q;
   logic                 crc_q;
   logic                 valid_q;
   logic                 chk_done_q;
   logic                 crc_err_q;

   // Data is folded in only while a frame is being absorbed; otherwise a plain shift.
   assign shift_only = !((state == ST_IDLE) || (state == ST_ACCUM && bus.active));
   assign bit_err    = bus.data ^ lfsr[0];

   crc_lfsr_step #(
      .CRC_WIDTH (CRC_WIDTH),
      .POLY      (POLY)
   ) u_step (
      .lfsr       (lfsr),
      .data_in    (bus.data),
      .shift_only (shift_only),
      .lfsr_next  (lfsr_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         lfsr       <= SEED;
         count      <= '0;
         mode_q     <= 1'b0;
         err_acc    <= 1'b0;
         ready_q    <= 1'b1;
         crc_q      <= 1'b0;
         valid_q    <= 1'b0;
         chk_done_q <= 1'b0;
         crc_err_q  <= 1'b0;
      end else begin
         chk_done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.active) begin
                  lfsr      <= lfsr_next;
                  mode_q    <= bus.mode;
                  crc_err_q <= 1'b0;
                  ready_q   <= 1'b0;
                  state     <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (bus.active) begin
                  lfsr <= lfsr_next;
               end else if (!mode_q) begin
                  crc_q   <= lfsr[0];
                  valid_q <= 1'b1;
                  lfsr    <= lfsr_next;
                  count   <= CNT_ONE;
                  state   <= ST_GEN;
               end else begin
                  count   <= '0;
                  err_acc <= 1'b0;
                  state   <= ST_CHK;
               end
            end
            ST_GEN: begin
               if (count == CNT_GEN_LAST) begin
                  valid_q <= 1'b0;
                  crc_q   <= 1'b0;
                  lfsr    <= SEED;
                  count   <= '0;
                  ready_q <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  crc_q <= lfsr[0];
                  lfsr  <= lfsr_next;
                  count <= count + CNT_ONE;
               end
            end
            ST_CHK: begin
               if (count == CNT_CHK_LAST) begin
                  crc_err_q  <= err_acc | bit_err;
                  chk_done_q <= 1'b1;
                  lfsr       <= SEED;
                  count      <= '0;
                  ready_q    <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  err_acc <= err_acc | bit_err;
                  lfsr    <= lfsr_next;
                  count   <= count + CNT_ONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ready    = ready_q;
   assign bus.crc      = crc_q;
   assign bus.valid    = valid_q;
   assign bus.chk_done = chk_done_q;
   assign bus.crc_err  = crc_err_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: default 8-bit instance plus a 16-bit reflected CCITT instance.
module tb_crc_serial_engine;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;

   crc_serial_engine_if i8 ();
   crc_serial_engine_if i16 ();

   crc_serial_engine u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (i8.slave)
   );

   crc_serial_engine #(
      .CRC_WIDTH (16),
      .POLY      (16'h8408),
      .SEED      (16'h0000)
   ) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (i16.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic a, input logic d, input logic m);
      if (sel == 1) begin
         i16.active = a; i16.data = d; i16.mode = m;
      end else begin
         i8.active = a; i8.data = d; i8.mode = m;
      end
   endtask

   function automatic logic get_valid(input int sel);
      return (sel == 1) ? i16.valid : i8.valid;
   endfunction
   function automatic logic get_crc(input int sel);
      return (sel == 1) ? i16.crc : i8.crc;
   endfunction
   function automatic logic get_ready(input int sel);
      return (sel == 1) ? i16.ready : i8.ready;
   endfunction

   function automatic logic [15:0] model_crc(input int w, input logic [15:0] poly,
                                             input logic [15:0] seed, input logic [63:0] data,
                                             input int nbits);
      logic [15:0] l;
      logic [15:0] mask;
      logic        fb;
      l    = seed;
      mask = 16'((32'd1 << (w - 1)) - 1);
      for (int j = 0; j < nbits; j++) begin
         fb = data[j] ^ l[0];
         l  = l >> 1;
         if (fb) l = l ^ (poly & mask);
         l[w-1] = fb;
      end
      return l;
   endfunction

   // Absorb nbits of data in generate mode, then collect the serial CRC.
   task automatic run_gen(input int sel, input logic [63:0] data, input int nbits,
                          input bit pulse_active, output logic [15:0] crc_out,
                          output int vcycles, output int ready_bad, output logic ready_after);
      crc_out   = '0;
      vcycles   = 0;
      ready_bad = 0;
      for (int j = 0; j < nbits; j++) begin
         drive(sel, 1'b1, data[j], 1'b0);
         tick();
         if (get_ready(sel)) ready_bad++;
      end
      drive(sel, 1'b0, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 40 && get_valid(sel); k++) begin
         if (vcycles < 16) crc_out[vcycles] = get_crc(sel);
         if (get_ready(sel)) ready_bad++;
         vcycles++;
         drive(sel, pulse_active && vcycles >= 2 && vcycles <= 4, 1'b1, 1'b0);
         tick();
      end
      drive(sel, 1'b0, 1'b0, 1'b0);
      ready_after = get_ready(sel);
   endtask

   task automatic run_chk(input logic [63:0] data, input int nbits, input logic [7:0] rx,
                          output logic err_seen, output int pulses, output int early);
      err_seen = 1'b0;
      pulses   = 0;
      early    = 0;
      for (int j = 0; j < nbits; j++) begin
         drive(0, 1'b1, data[j], 1'b1);
         tick();
      end
      drive(0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 8; k++) begin
         drive(0, 1'b0, rx[k], 1'b0);
         tick();
         if (i8.chk_done) begin
            pulses++;
            err_seen = i8.crc_err;
            if (k != 7) early++;
         end
      end
      drive(0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         if (i8.chk_done) pulses++;
      end
   endtask

   task automatic test_reset;
      total_cnt++; if (i8.ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", i8.ready); else pass_cnt++;
      total_cnt++; if (i8.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", i8.valid); else pass_cnt++;
      total_cnt++; if (i8.crc !== 1'b0) $display("FAIL reset_crc: got %b want 0", i8.crc); else pass_cnt++;
      total_cnt++; if (i8.chk_done !== 1'b0) $display("FAIL reset_chk_done: got %b want 0", i8.chk_done); else pass_cnt++;
      total_cnt++; if (i8.crc_err !== 1'b0) $display("FAIL reset_crc_err: got %b want 0", i8.crc_err); else pass_cnt++;
      total_cnt++; if (i16.ready !== 1'b1) $display("FAIL reset_ready16: got %b want 1", i16.ready); else pass_cnt++;
   endtask

   task automatic test_gen_zero;
      logic [15:0] c; int vc; int rb; logic ra;
      run_gen(0, 64'h0, 8, 1'b0, c, vc, rb, ra);
      total_cnt++; if (c !== 16'h0014) $display("FAIL gen_zero_crc: got %h want 0014", c); else pass_cnt++;
      total_cnt++; if (vc != 8) $display("FAIL gen_zero_valid_len: got %0d want 8", vc); else pass_cnt++;
      total_cnt++; if (rb != 0) $display("FAIL gen_zero_ready_low: got %0d high cycles want 0", rb); else pass_cnt++;
      total_cnt++; if (ra !== 1'b1) $display("FAIL gen_zero_ready_after: got %b want 1", ra); else pass_cnt++;
   endtask

   task automatic test_check;
      logic e; int p; int early; int waited;
      run_chk(64'h0, 8, 8'h14, e, p, early);
      total_cnt++; if (p != 1 || early != 0) $display("FAIL chk_good_pulse: got %0d pulses (%0d early) want 1", p, early); else pass_cnt++;
      total_cnt++; if (e !== 1'b0) $display("FAIL chk_good_err: got %b want 0", e); else pass_cnt++;
      run_chk(64'h0, 8, 8'h15, e, p, early);
      total_cnt++; if (p != 1 || early != 0) $display("FAIL chk_bad_pulse: got %0d pulses (%0d early) want 1", p, early); else pass_cnt++;
      total_cnt++; if (e !== 1'b1) $display("FAIL chk_bad_err: got %b want 1", e); else pass_cnt++;
      total_cnt++; if (i8.crc_err !== 1'b1) $display("FAIL chk_err_held: got %b want 1", i8.crc_err); else pass_cnt++;
      drive(0, 1'b1, 1'b0, 1'b0);
      tick();
      total_cnt++; if (i8.crc_err !== 1'b0) $display("FAIL chk_err_cleared: got %b want 0", i8.crc_err); else pass_cnt++;
      for (int j = 1; j < 8; j++) tick();
      drive(0, 1'b0, 1'b0, 1'b0);
      tick();
      waited = 0;
      while (!i8.ready && waited < 20) begin
         tick();
         waited++;
      end
      total_cnt++; if (i8.ready !== 1'b1) $display("FAIL chk_followup_ready: got %b want 1 after %0d cycles", i8.ready, waited); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      logic [15:0] c; int vc; int rb; logic ra; logic [63:0] d; logic [15:0] exp;
      for (int f = 0; f < 10; f++) begin
         d   = 64'($urandom_range(0, 255));
         exp = model_crc(8, 16'h0044, 16'h00D8, d, 8);
         run_gen(0, d, 8, 1'b0, c, vc, rb, ra);
         total_cnt++;
         if (c !== exp || vc != 8 || ra !== 1'b1)
            $display("FAIL b2b_frame%0d: data %h got crc %h len %0d ready %b want crc %h len 8 ready 1",
                     f, d[7:0], c, vc, ra, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_active_in_gen;
      logic [15:0] c; int vc; int rb; logic ra;
      run_gen(0, 64'h0, 8, 1'b1, c, vc, rb, ra);
      total_cnt++; if (vc != 8) $display("FAIL gen_active_len: got %0d want 8", vc); else pass_cnt++;
      total_cnt++; if (c !== 16'h0014) $display("FAIL gen_active_crc: got %h want 0014", c); else pass_cnt++;
   endtask

   task automatic test_reset_abort;
      logic [15:0] c; int vc; int rb; logic ra; int vseen;
      vseen = 0;
      for (int j = 0; j < 8; j++) begin
         drive(0, 1'b1, 1'b0, 1'b0);
         tick();
      end
      drive(0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         if (i8.valid) vseen++;
         if (k < 3) tick();
      end
      total_cnt++; if (vseen != 4) $display("FAIL abort_prefix_valid: got %0d want 4", vseen); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++; if (i8.valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", i8.valid); else pass_cnt++;
      total_cnt++; if (i8.ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", i8.ready); else pass_cnt++;
      total_cnt++; if (i8.crc !== 1'b0) $display("FAIL abort_crc: got %b want 0", i8.crc); else pass_cnt++;
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      total_cnt++; if (i8.valid !== 1'b0) $display("FAIL abort_no_tail: got %b want 0", i8.valid); else pass_cnt++;
      run_gen(0, 64'h0, 8, 1'b0, c, vc, rb, ra);
      total_cnt++; if (c !== 16'h0014 || vc != 8) $display("FAIL abort_fresh: got crc %h len %0d want 0014 len 8", c, vc); else pass_cnt++;
   endtask

   task automatic test_width16;
      logic [15:0] c; int vc; int rb; logic ra; logic [63:0] d; logic [15:0] exp;
      run_gen(1, 64'h0, 16, 1'b0, c, vc, rb, ra);
      total_cnt++; if (vc != 16) $display("FAIL w16_zero_len: got %0d want 16", vc); else pass_cnt++;
      total_cnt++; if (c !== 16'h0000) $display("FAIL w16_zero_crc: got %h want 0000", c); else pass_cnt++;
      // One bit set: the register ends as the reflected polynomial with the implicit top bit.
      run_gen(1, 64'h1, 1, 1'b0, c, vc, rb, ra);
      total_cnt++; if (c !== 16'h8408) $display("FAIL w16_one_bit: got %h want 8408", c); else pass_cnt++;
      for (int f = 0; f < 3; f++) begin
         d   = 64'($urandom_range(0, 65535));
         exp = model_crc(16, 16'h8408, 16'h0000, d, 16);
         run_gen(1, d, 16, 1'b0, c, vc, rb, ra);
         total_cnt++;
         if (c !== exp || vc != 16)
            $display("FAIL w16_rand%0d: data %h got %h len %0d want %h len 16", f, d[15:0], c, vc, exp);
         else pass_cnt++;
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst_n     = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0);
      #22 rst_n = 1'b1;
      tick();
      test_reset();
      test_gen_zero();
      test_check();
      test_back_to_back();
      test_active_in_gen();
      test_reset_abort();
      test_width16();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
- Parametrised, serial, bit-at-a-time CRC engine. Successor to the fixed 8-bit generator: CRC width, polynomial and seed are configurable.
- Adds a receive-side check mode, a READY indication and a counted output phase.
- Sits between a serial framer and the line interface.
- Generate mode absorbs frame bits, then shifts the CRC out LSB-first. Check mode absorbs frame bits, then compares the received CRC bits and flags a mismatch.

Parameters:
- CRC_WIDTH, 8, LFSR/CRC width in bits, >= 2.
- POLY, 8'h44, feedback tap mask over bits [CRC_WIDTH-2:0]; the x^CRC_WIDTH term is implicit.
- SEED, 8'hD8, LFSR value loaded on reset and at the end of every frame.

Ports:
- CLK  input  1  single clock, all state on rising edge.
- RST  input  1  asynchronous, active-low reset.
- DATA  input  1  serial frame bit (LSB-first); in check mode also carries the received CRC bits.
- ACTIVE  input  1  high while frame bits are presented.
- MODE  input  1  0 = generate, 1 = check; sampled on the first ACTIVE cycle of a frame.
- READY  output  1  high when a new frame may start (state IDLE).
- CRC  output  1  serial CRC bit, registered.
- Valid  output  1  high for exactly CRC_WIDTH cycles while CRC carries bits (generate mode).
- CHK_DONE  output  1  one-cycle pulse at the end of the check phase.
- CRC_ERR  output  1  registered mismatch result, valid from the CHK_DONE cycle until the next frame starts.

Behaviour:
- Reset (RST=0, asynchronous):
  - LFSR=SEED, state=IDLE, count=0.
  - CRC=0, Valid=0, CHK_DONE=0, CRC_ERR=0, READY=1.
  - Reset asserted mid-frame or mid-output aborts immediately; no partial output is emitted after release.
- LFSR step (Galois, right shift):
  - fb = DATA ^ L[0].
  - L'[CRC_WIDTH-1] = fb.
  - For i < CRC_WIDTH-1: L'[i] = L[i+1] ^ (POLY[i] & fb).
- States:
  - IDLE:
    - READY=1.
    - ACTIVE=1 -> step LFSR with DATA, latch MODE, clear CRC_ERR, go ACCUM. The first bit is absorbed on the same edge.
  - ACCUM:
    - ACTIVE=1 -> step LFSR.
    - ACTIVE=0 and mode=0 -> go GEN. On this edge: CRC<=L[0], Valid<=1, L<=L>>1 (zero fill), count<=1.
    - ACTIVE=0 and mode=1 -> go CHK, count<=0. DATA is not absorbed on this edge.
  - GEN:
    - count<CRC_WIDTH -> CRC<=L[0], L<=L>>1, count++.
    - count==CRC_WIDTH -> Valid<=0, CRC<=0, L<=SEED, go IDLE.
    - Valid is therefore high for exactly CRC_WIDTH consecutive cycles; latency is 1 edge from ACTIVE sampled low to the first CRC bit.
  - CHK:
    - Each cycle: err_acc |= DATA ^ L[0]; L<=L>>1; count++.
    - After CRC_WIDTH compares: CRC_ERR<=err_acc, CHK_DONE<=1 for one cycle, L<=SEED, go IDLE.
    - ACTIVE is don't-care in CHK.
- READY=0 in ACCUM, GEN and CHK. ACTIVE asserted in GEN or CHK is ignored: no absorption, and no frame starts until IDLE.
- A frame started on the cycle after return to IDLE is legal (back-to-back frames).
- count width is clog2(CRC_WIDTH+1); no wrap is possible.
- Frame length is unbounded.

Decomposition:
- Package crc_pkg holds:
  - state encoding (IDLE, ACCUM, GEN, CHK);
  - default CRC_WIDTH/POLY/SEED constants;
  - a count-width function.
- Sub-module crc_lfsr_step: combinational next-LFSR from (L, DATA_in, shift_only), parametrised by CRC_WIDTH and POLY. The top holds the FSM, counter and output registers.

Test Plan:
- Defaults, generate, DATA byte 0x00 LSB-first with ACTIVE high 8 cycles -> Valid high exactly 8 cycles, CRC bits assemble (bit j in cycle j) to 0x14, READY low throughout, returns high after.
- Check mode, frame 0x00 then received CRC bits of 0x14 -> CHK_DONE pulses once, CRC_ERR=0. Repeat with 0x15 -> CRC_ERR=1, held until the next frame's first ACTIVE cycle, then cleared.
- Ten back-to-back generate frames (next ACTIVE on the cycle READY rises) -> each CRC matches the reference model; LFSR reseeded to 0xD8 between frames.
- ACTIVE pulsed high during GEN -> ignored: Valid stays high for all 8 cycles and the CRC value is unchanged.
- RST driven low at the 4th Valid cycle, asynchronously between edges -> Valid, CRC and READY reach reset values immediately; after release, a fresh 0x00 frame yields 0x14.
- Override CRC_WIDTH=16, POLY=16'h1021 bit-reversed equivalent, SEED=0, data 16 zeros -> Valid high 16 cycles, CRC=0x0000. Random frames must match the bench model.
